// File: rtl/loop_mon_pkg.sv
// Shared definitions for the loop oscillation monitor: FSM states and
// default measurement timing.
package loop_mon_pkg;

  localparam int unsigned SETTLE_DEF = 4;
  localparam int unsigned WIN_DEF    = 16;
  localparam int unsigned THRESH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_WATCH  = 2'd2,
    ST_REPORT = 2'd3
  } mon_state_e;

endpackage

// File: rtl/toggle_counter.sv
// Per-net saturating toggle counter; compares the synchronized bit against
// its value one cycle earlier and exposes the next count combinationally.
module toggle_counter #(
  parameter int unsigned WIN = 16,
  parameter int unsigned CW  = $clog2(WIN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  input  logic          bit_i,
  output logic [CW-1:0] cnt_d_c
);

  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (bit_i != prev_q) && (cnt_q != CW'(WIN))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // prev_q tracks every cycle so the first counted cycle compares
  // against the last uncounted one
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= bit_i;
      cnt_q  <= cnt_d;
    end
  end

  assign cnt_d_c = cnt_d;

endmodule

// File: rtl/loop_osc_monitor.sv
// Measures toggle activity on asynchronous loop nets over a fixed window
// after a settle period and holds the result until the consumer accepts it.
module loop_osc_monitor
  import loop_mon_pkg::*;
#(
  parameter int unsigned NETS   = 3,
  parameter int unsigned SETTLE = SETTLE_DEF,
  parameter int unsigned WIN    = WIN_DEF,
  parameter int unsigned THRESH = THRESH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [NETS-1:0]            net_in,
  output logic                       busy,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [NETS-1:0]            osc_mask,
  output logic [NETS-1:0]            stable_val,
  output logic [$clog2(WIN+1)-1:0]   toggle_max
);

  localparam int unsigned CW   = $clog2(WIN + 1);
  localparam int unsigned PMAX = (SETTLE > WIN) ? SETTLE : WIN;
  localparam int unsigned PW   = $clog2(PMAX + 1);

  mon_state_e      state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [NETS-1:0] sync1_q, sync2_q;
  logic [NETS-1:0] osc_q, osc_d;
  logic [NETS-1:0] stable_q;
  logic [CW-1:0]   max_q, max_c;
  logic            clr_c, cnt_en_c, capture_c;
  logic [CW-1:0]   cnt_next_c [NETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= net_in;
      sync2_q <= sync1_q;
    end
  end

  for (genvar g = 0; g < NETS; g++) begin : g_cnt
    toggle_counter #(
      .WIN (WIN),
      .CW  (CW)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr_i   (clr_c),
      .en_i    (cnt_en_c),
      .bit_i   (sync2_q[g]),
      .cnt_d_c (cnt_next_c[g])
    );
  end

  // Result is built from next-cycle counts so the final WATCH toggle is included
  always_comb begin
    max_c = '0;
    osc_d = '0;
    for (int unsigned i = 0; i < NETS; i++) begin
      osc_d[i] = (32'(cnt_next_c[i]) >= THRESH);
      if (cnt_next_c[i] > max_c) max_c = cnt_next_c[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    clr_c     = 1'b0;
    cnt_en_c  = 1'b0;
    capture_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SETTLE;
          phase_d = '0;
          clr_c   = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (phase_q == PW'(SETTLE - 1)) begin
          state_d = ST_WATCH;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_WATCH: begin
        cnt_en_c = 1'b1;
        if (phase_q == PW'(WIN - 1)) begin
          state_d   = ST_REPORT;
          phase_d   = '0;
          capture_c = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_REPORT: begin
        if (valid_q && result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d  = (state_d != ST_IDLE);
    valid_d = (state_d == ST_REPORT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      osc_q    <= '0;
      stable_q <= '0;
      max_q    <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      if (capture_c) begin
        osc_q    <= osc_d;
        stable_q <= sync2_q;
        max_q    <= max_c;
      end
    end
  end

  assign busy         = busy_q;
  assign result_valid = valid_q;
  assign osc_mask     = osc_q;
  assign stable_val   = stable_q;
  assign toggle_max   = max_q;

endmodule

// File: tb/tb_loop_osc_monitor.sv
// Randomized self-checking bench for loop_osc_monitor against a model that
// derives results from the raw net_in history and the 2-cycle sync lag.
module tb_loop_osc_monitor;

  localparam int unsigned NETS   = 3;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned WIN    = 16;
  localparam int unsigned THRESH = 4;
  localparam int unsigned CW     = $clog2(WIN + 1);
  localparam int          LAT    = SETTLE + WIN + 1;
  localparam int          HLEN   = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            result_ready = 1'b0;
  logic [NETS-1:0] net_in = '0;
  logic            busy;
  logic            result_valid;
  logic [NETS-1:0] osc_mask;
  logic [NETS-1:0] stable_val;
  logic [CW-1:0]   toggle_max;

  int n_checks = 0;
  int n_errors = 0;

  logic [NETS-1:0] hist [HLEN];
  logic [NETS-1:0] exp_osc;
  logic [NETS-1:0] exp_stable;
  logic [CW-1:0]   exp_max;

  loop_osc_monitor #(
    .NETS   (NETS),
    .SETTLE (SETTLE),
    .WIN    (WIN),
    .THRESH (THRESH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .net_in       (net_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .osc_mask     (osc_mask),
    .stable_val   (stable_val),
    .toggle_max   (toggle_max)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // hist[k] is net_in during cycle k (cycle 0 = start cycle); the synchronized
  // value seen in cycle c is hist[c-2]; WATCH covers cycles SETTLE+1..SETTLE+WIN
  task automatic model();
    int cnt [NETS];
    int mx;
    for (int i = 0; i < NETS; i++) cnt[i] = 0;
    for (int c = SETTLE + 1; c <= SETTLE + WIN; c++)
      for (int i = 0; i < NETS; i++)
        if (hist[c-2][i] != hist[c-3][i]) cnt[i]++;
    mx = 0;
    for (int i = 0; i < NETS; i++) begin
      if (cnt[i] > int'(WIN)) cnt[i] = WIN;
      exp_osc[i] = (cnt[i] >= int'(THRESH));
      if (cnt[i] > mx) mx = cnt[i];
    end
    exp_max    = CW'(mx);
    exp_stable = hist[SETTLE + WIN - 2];
  endtask

  // 0 const 101, 1 net1 toggles every cycle, 2 net0 x4 / net2 x3,
  // 3 toggles only during settle, 4 random per-bit activity
  task automatic build(input int mode);
    logic [NETS-1:0] v;
    int rate [NETS];
    v = NETS'($urandom);
    for (int i = 0; i < NETS; i++) rate[i] = $urandom_range(0, 3);
    for (int k = 0; k < HLEN; k++) begin
      case (mode)
        0: v = 3'b101;
        1: v[1] = ~v[1];
        2: begin
          if (k == 4 || k == 6 || k == 8 || k == 10) v[0] = ~v[0];
          if (k == 5 || k == 9 || k == 13) v[2] = ~v[2];
        end
        3: begin
          if (k == 1) v = ~v;
          if (k == 2) v = v ^ NETS'($urandom);
        end
        default: begin
          for (int i = 0; i < NETS; i++)
            if (rate[i] == 3 || (rate[i] != 0 && $urandom_range(0, 3) < rate[i]))
              v[i] = ~v[i];
        end
      endcase
      hist[k] = v;
    end
  endtask

  // Caller enters at a point away from the rising edge
  task automatic measure(input int hold, input bit use_lit, input logic [NETS-1:0] lit_osc,
                         input bit use_stable, input logic [NETS-1:0] lit_stable,
                         input logic [CW-1:0] lit_max);
    model();
    start  = 1'b1;
    net_in = hist[0];
    for (int c = 1; c <= LAT; c++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      net_in = hist[c];
      if (c == 1) check_val("busy_after_start", 32'(busy), 1);
      if (c == LAT - 1) check_val("valid_before_latency", 32'(result_valid), 0);
    end
    check_val("valid_at_latency", 32'(result_valid), 1);
    check_val("osc_mask", 32'(osc_mask), 32'(exp_osc));
    check_val("stable_val", 32'(stable_val), 32'(exp_stable));
    check_val("toggle_max", 32'(toggle_max), 32'(exp_max));
    if (use_lit) begin
      check_val("osc_mask_lit", 32'(osc_mask), 32'(lit_osc));
      check_val("toggle_max_lit", 32'(toggle_max), 32'(lit_max));
    end
    if (use_stable) check_val("stable_val_lit", 32'(stable_val), 32'(lit_stable));
    for (int h = 0; h < hold; h++) begin
      start  = 1'($urandom_range(0, 1));
      net_in = NETS'($urandom);
      @(posedge clk); #1;
      check_val("hold_valid", 32'(result_valid), 1);
      check_val("hold_busy", 32'(busy), 1);
      check_val("hold_osc", 32'(osc_mask), 32'(exp_osc));
      check_val("hold_stable", 32'(stable_val), 32'(exp_stable));
      check_val("hold_max", 32'(toggle_max), 32'(exp_max));
    end
    start        = 1'b1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    result_ready = 1'b0;
    check_val("busy_after_accept", 32'(busy), 0);
    check_val("valid_after_accept", 32'(result_valid), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_valid", 32'(result_valid), 0);
    check_val("rst_osc", 32'(osc_mask), 0);
    check_val("rst_stable", 32'(stable_val), 0);
    check_val("rst_max", 32'(toggle_max), 0);
    rst = 1'b0;

    build(0); measure(0, 1'b1, 3'b000, 1'b1, 3'b101, CW'(0));
    build(1); measure(0, 1'b1, 3'b010, 1'b0, 3'b000, CW'(WIN));
    build(2); measure(0, 1'b1, 3'b001, 1'b0, 3'b000, CW'(4));
    build(1); measure(10, 1'b1, 3'b010, 1'b0, 3'b000, CW'(WIN));

    // reset in the 8th WATCH cycle after a result with a nonzero mask
    build(1);
    start  = 1'b1;
    net_in = hist[0];
    for (int c = 1; c <= SETTLE + 8; c++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      net_in = hist[c];
    end
    check_val("busy_mid_watch", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check_val("midrst_busy", 32'(busy), 0);
    check_val("midrst_valid", 32'(result_valid), 0);
    check_val("midrst_osc", 32'(osc_mask), 0);
    check_val("midrst_stable", 32'(stable_val), 0);
    check_val("midrst_max", 32'(toggle_max), 0);
    @(negedge clk);
    rst = 1'b0;
    build(4); measure(0, 1'b0, 3'b000, 1'b0, 3'b000, CW'(0));

    build(3); measure(0, 1'b1, 3'b000, 1'b0, 3'b000, CW'(0));

    for (int n = 0; n < 10; n++) begin
      build(4);
      measure($urandom_range(0, 3), 1'b0, 3'b000, 1'b0, 3'b000, CW'(0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/loop_osc_monitor.md
LOOP_OSC_MONITOR -- requirements
Module: loop_osc_monitor

Interface
REQ-001 The parameter NETS SHALL default to 3 and sets the number of monitored loop nets.
REQ-002 The parameter SETTLE SHALL default to 4 and sets the number of cycles ignored after start.
REQ-003 The parameter WIN SHALL default to 16 and sets the observation window length in cycles.
REQ-004 The parameter THRESH SHALL default to 4 and sets the toggle count at which a net is flagged oscillating.
REQ-005 The port clk SHALL be an input of width 1 and is the single clock.
REQ-006 The port rst SHALL be an input of width 1 and is an asynchronous, active-high reset.
REQ-007 The port start SHALL be an input of width 1 and requests one measurement.
REQ-008 The port net_in SHALL be an input of width NETS and carries raw loop-net values, asynchronous to clk.
REQ-009 The port busy SHALL be an output of width 1 and is high in any state other than IDLE.
REQ-010 The port result_valid SHALL be an output of width 1 and indicates that a result is held.
REQ-011 The port result_ready SHALL be an input of width 1 and is the consumer's acceptance.
REQ-012 The port osc_mask SHALL be an output of width NETS, and bit i SHALL be set when net i toggled THRESH or more times in the window.
REQ-013 The port stable_val SHALL be an output of width NETS and holds the synchronized net values sampled in the last WATCH cycle.
REQ-014 The port toggle_max SHALL be an output of width clog2(WIN+1) and holds the highest per-net toggle count in the window.

Function
REQ-015 net_in SHALL pass through a 2-flop synchronizer per bit, so all observations lag net_in by 2 cycles.
REQ-016 The FSM SHALL have the states IDLE, SETTLE, WATCH and REPORT.
REQ-017 In IDLE, start=1 SHALL move the FSM to SETTLE on the next edge and clear all toggle counters.
REQ-018 SETTLE SHALL last exactly SETTLE cycles, then move to WATCH; toggles during SETTLE SHALL NOT be counted.
REQ-019 WATCH SHALL last exactly WIN cycles, and each cycle a counter SHALL increment for each net whose synchronized value differs from the previous cycle's value.
REQ-020 The comparison reference in the first WATCH cycle SHALL be the value from the last SETTLE cycle.
REQ-021 Toggle counters SHALL saturate at WIN and never wrap.
REQ-022 On the WATCH to REPORT transition, the block SHALL register osc_mask, stable_val and toggle_max, and result_valid SHALL rise in the first REPORT cycle.
REQ-023 In REPORT, result_valid SHALL stay high and the outputs SHALL stay frozen until result_valid && result_ready, after which the FSM SHALL return to IDLE on that edge.
REQ-024 start SHALL be ignored in every state other than IDLE, including in the same cycle as the REPORT handshake.
REQ-025 When THRESH is 0, every bit of osc_mask SHALL be set; when THRESH is greater than WIN, no bit SHALL be set.
REQ-026 Total latency from start to result_valid SHALL be SETTLE+WIN+1 cycles.

Reset
REQ-027 Asserting rst SHALL asynchronously force the state to IDLE and clear the synchronizers, the counters, busy, result_valid, osc_mask, stable_val and toggle_max, including when rst is asserted in mid-measurement or in REPORT.
REQ-028 After rst deasserts, the first start SHALL be accepted on the first clk edge.

Structure
REQ-029 A shared package loop_mon_pkg SHALL hold the state enum and the default values of SETTLE, WIN and THRESH.
REQ-030 The per-net saturating toggle counter with its previous-value flop SHALL be a sub-module named toggle_counter, instantiated NETS times.

Verification
REQ-031 With net_in held at 3'b101 and start pulsed, the bench SHALL see result_valid after 21 cycles, osc_mask=000, stable_val=101 and toggle_max=0.
REQ-032 With net_in[1] toggling every cycle and the others constant, the bench SHALL see osc_mask=010 and toggle_max=16 (saturated).
REQ-033 With net_in[2] toggling 3 times in the window and net_in[0] toggling 4 times, the bench SHALL see osc_mask=001 and toggle_max=4.
REQ-034 With result_ready held low for 10 cycles, result_valid and the outputs SHALL stay frozen and start SHALL be ignored; after ready rises, busy=0 on the next cycle.
REQ-035 With rst asserted in cycle 8 of WATCH, all outputs SHALL be 0 immediately, and a fresh start SHALL yield a full SETTLE+WIN measurement.
REQ-036 With net_in toggling only during SETTLE, the bench SHALL see osc_mask=000.
